axi4_lite_write_arbiter: RTL

- Shares one AXI4-Lite write-master request interface between NUM_REQ requesters, e.g. D-cache writeback and uncached/MMIO store path.
- Accepts requests and arbitrates them round-robin.
- Latches the winner's address/data, issues one start pulse to the write master, then holds the grant until the write master reports completion.
- Routes done/fault back to the granted requester only.

---
 rtl/axi4_lite_write_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/axi4_lite_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_write_arbiter
// Description : Round-robin arbiter sharing one AXI4-Lite write-master request
//               port between NUM_REQ requesters. The winner's address/data are
//               latched, a single start pulse is issued, and the grant is held
//               until the write master reports completion. done/fault are
//               routed back to the granted requester only.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_write_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                              clk_i,
    input  logic                              arst_i,
    input  logic [NUM_REQ-1:0]                req_i,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]                req_done_o,
    output logic [NUM_REQ-1:0]                req_fault_o,
    output logic [AXI_ADDR_WIDTH-1:0]         wr_addr_o,
    output logic [AXI_DATA_WIDTH-1:0]         wr_data_o,
    output logic                              wr_start_o,
    input  logic                              wr_done_i,
    input  logic                              wr_fault_i,
    output logic                              busy_o,
    output logic [IDX_W-1:0]                  grant_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(NUM_REQ - 1);

    state_t                    r_state;
    logic [IDX_W-1:0]          r_rr_ptr;

    logic                      w_found;
    logic [IDX_W-1:0]          w_winner;
    logic [IDX_W-1:0]          w_cand;
    int                        w_sum;

    logic [AXI_ADDR_WIDTH-1:0] w_addr_arr [NUM_REQ];
    logic [AXI_DATA_WIDTH-1:0] w_data_arr [NUM_REQ];

    // Unpack the flat address/data buses into per-requester slots
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr_arr[g] = req_addr_i[g*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        assign w_data_arr[g] = req_data_i[g*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    end

    // Round-robin search: first active request starting at rr_ptr, wrapping
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        w_sum    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = int'(r_rr_ptr) + i;
            if (w_sum >= NUM_REQ) begin
                w_sum = w_sum - NUM_REQ;
            end
            w_cand = IDX_W'(w_sum);
            if (!w_found && req_i[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // Completion is returned in the same cycle wr_done_i arrives, to the grantee only
    always_comb begin
        req_done_o  = '0;
        req_fault_o = '0;
        if (r_state == ST_WAIT && wr_done_i) begin
            req_done_o[grant_o]  = 1'b1;
            req_fault_o[grant_o] = wr_fault_i;
        end
    end

    assign busy_o = (r_state != ST_IDLE);

    // Arbitration FSM with registered grant, latched request and start pulse
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            grant_o    <= '0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
            wr_start_o <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    wr_start_o <= 1'b0;
                    if (w_found) begin
                        grant_o    <= w_winner;
                        wr_addr_o  <= w_addr_arr[w_winner];
                        wr_data_o  <= w_data_arr[w_winner];
                        wr_start_o <= 1'b1;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    // The pulse raised on entry lasts exactly this one cycle
                    wr_start_o <= 1'b0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    wr_start_o <= 1'b0;
                    if (wr_done_i) begin
                        r_rr_ptr <= (grant_o == c_LAST) ? '0 : grant_o + 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    wr_start_o <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
